// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply, restoring divide,
// WIDTH iterations per operation, result written back to the register file.
module mul_div_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_reg,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [ADDR_W-1:0] result_reg,
  output logic              result_write,
  output logic              div_by_zero,
  output logic [1:0]        debug_state
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MULLO = 2'b00;
  localparam logic [1:0] OP_MULHI = 2'b01;
  localparam logic [1:0] OP_DIVQ  = 2'b10;

  state_t            state;
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [ADDR_W-1:0] dest_q;
  logic [CNT_W-1:0]  count;
  // acc: product high half (MUL) or partial remainder (DIV).
  // lo:  multiplier shifting out / product low half shifting in (MUL),
  //      dividend shifting out / quotient shifting in (DIV).
  logic [WIDTH:0]    acc;
  logic [WIDTH-1:0]  lo;

  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic              div_ok;
  logic [WIDTH:0]    acc_nx;
  logic [WIDTH-1:0]  lo_nx;
  logic [WIDTH-1:0]  result_nx;
  logic              accept;

  assign debug_state = state;
  // A start in the DONE cycle is taken so operations can issue back-to-back.
  assign accept = start && (state == S_IDLE || state == S_DONE);

  always_comb begin
    mul_sum   = {1'b0, acc[WIDTH-1:0]} + (lo[0] ? {1'b0, a_q} : '0);
    div_shift = {acc[WIDTH-1:0], lo[WIDTH-1]};
    div_ok    = div_shift >= {1'b0, b_q};
    acc_nx    = acc;
    lo_nx     = lo;
    if (op_q[1]) begin
      acc_nx = div_ok ? (div_shift - {1'b0, b_q}) : div_shift;
      lo_nx  = {lo[WIDTH-2:0], div_ok};
    end else begin
      acc_nx = {1'b0, mul_sum[WIDTH:1]};
      lo_nx  = {mul_sum[0], lo[WIDTH-1:1]};
    end
    case (op_q)
      OP_MULLO: result_nx = lo_nx;
      OP_MULHI: result_nx = acc_nx[WIDTH-1:0];
      OP_DIVQ:  result_nx = lo_nx;
      default:  result_nx = acc_nx[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_write <= 1'b0;
      div_by_zero  <= 1'b0;
      result       <= '0;
      result_reg   <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      dest_q       <= '0;
      count        <= '0;
      acc          <= '0;
      lo           <= '0;
    end else begin
      done         <= 1'b0;
      result_write <= 1'b0;
      case (state)
        S_RUN: begin
          acc   <= acc_nx;
          lo    <= lo_nx;
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state        <= S_DONE;
            done         <= 1'b1;
            result_write <= 1'b1;
            result       <= result_nx;
            result_reg   <= dest_q;
            div_by_zero  <= op_q[1] && (b_q == '0);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (accept) begin
        state  <= S_RUN;
        busy   <= 1'b1;
        op_q   <= op;
        a_q    <= operand_a;
        b_q    <= operand_b;
        dest_q <= dest_reg;
        count  <= '0;
        acc    <= '0;
        // Multiply consumes the multiplier LSB first, divide the dividend MSB first.
        lo     <= op[1] ? operand_a : operand_b;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus randomized operations checked
// against an arithmetic reference model, with cycle-exact done timing.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [3:0]  dest_reg;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  result_reg;
  logic        result_write;
  logic        div_by_zero;
  logic [1:0]  debug_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  exp_reg_q[$];
  logic        exp_dbz_q[$];
  logic [15:0] last_result;

  mul_div_unit #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .busy(busy), .done(done), .result(result), .result_reg(result_reg),
    .result_write(result_write), .div_by_zero(div_by_zero),
    .debug_state(debug_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 16'h0) ? 16'hFFFF : a / b;
      default: return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  // driver tasks: all are entered and left 1 time unit after a rising edge
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    dest_reg  = d;
    exp_q.push_back(ref_result(o, a, b));
    exp_reg_q.push_back(d);
    exp_dbz_q.push_back(o[1] && (b == 16'h0));
  endtask

  task automatic wait_result(input string tag, input bit chain, input bit poke,
                             input logic [1:0] no, input logic [15:0] na,
                             input logic [15:0] nb, input logic [3:0] nd);
    int bad;
    logic [15:0] e;
    @(posedge clk); #1;  // cycle after E0
    start     = 1'b0;
    operand_a = 16'($urandom);
    operand_b = 16'($urandom);
    dest_reg  = 4'($urandom);
    op        = 2'($urandom);
    bad = 0;
    if (!busy || done || result_write || result !== last_result) bad++;
    for (int k = 1; k <= 15; k++) begin
      start = poke && (k == 5);
      @(posedge clk); #1;
      if (!busy || done || result_write || result !== last_result) bad++;
    end
    start = 1'b0;
    @(posedge clk); #1;  // cycle after E16
    e = exp_q.pop_front();
    check({tag, " run"}, 32'(bad), 32'd0);
    check({tag, " done"}, {busy, done, result_write}, 3'b111);
    check({tag, " result"}, result, e);
    check({tag, " reg"}, result_reg, exp_reg_q.pop_front());
    check({tag, " dbz"}, div_by_zero, exp_dbz_q.pop_front());
    last_result = e;
    if (chain) begin
      issue(no, na, nb, nd);
    end else begin
      @(posedge clk); #1;
      check({tag, " idle"}, {busy, done, result_write, result}, {3'b000, e});
    end
  endtask

  task automatic rand_operands(output logic [1:0] o, output logic [15:0] a,
                               output logic [15:0] b, output logic [3:0] d);
    o = 2'($urandom_range(0, 3));
    a = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       b = 16'h0;
      1, 2:    b = 16'($urandom_range(1, 20));
      3:       b = 16'hFFFF;
      default: b = 16'($urandom);
    endcase
    d = 4'($urandom);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    logic [3:0]  rd;
    int          strobes;
    bit          ch;

    reset = 1'b1; start = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0; dest_reg = '0;
    last_result = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset outs", {busy, done, result_write, div_by_zero, result, result_reg, debug_state},
          '0);
    reset = 1'b0;

    // directed cases
    issue(2'b00, 16'h1234, 16'h0010, 4'd3);  wait_result("mullo", 0, 0, 0, 0, 0, 0);
    issue(2'b01, 16'hFFFF, 16'hFFFF, 4'd5);  wait_result("mulhi max", 0, 0, 0, 0, 0, 0);
    issue(2'b00, 16'hFFFF, 16'hFFFF, 4'd6);  wait_result("mullo max", 0, 0, 0, 0, 0, 0);
    issue(2'b10, 16'h03E8, 16'h0007, 4'd7);  wait_result("divq 1000/7", 0, 0, 0, 0, 0, 0);
    issue(2'b11, 16'h03E8, 16'h0007, 4'd8);  wait_result("divr 1000/7", 0, 0, 0, 0, 0, 0);
    issue(2'b10, 16'h1234, 16'h0000, 4'd9);  wait_result("divq by 0", 0, 0, 0, 0, 0, 0);
    issue(2'b11, 16'h1234, 16'h0000, 4'd10); wait_result("divr by 0", 0, 0, 0, 0, 0, 0);
    issue(2'b00, 16'h0003, 16'h0004, 4'd11); wait_result("dbz clear", 0, 0, 0, 0, 0, 0);
    issue(2'b01, 16'hABCD, 16'h1357, 4'd12); wait_result("start in run", 0, 1, 0, 0, 0, 0);

    // back-to-back: second op accepted on E17
    issue(2'b00, 16'h1234, 16'h0010, 4'd3);
    wait_result("b2b first", 1, 0, 2'b11, 16'h00FF, 16'h0010, 4'd4);
    wait_result("b2b second", 0, 0, 0, 0, 0, 0);

    // reset at E8 aborts the operation
    start = 1'b1; op = 2'b01; operand_a = 16'h7777; operand_b = 16'h9999; dest_reg = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort outs", {busy, done, result_write, div_by_zero, result, result_reg, debug_state},
          '0);
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (result_write || done || busy) strobes++;
    end
    check("abort quiet", 32'(strobes), 32'd0);
    last_result = '0;

    // randomized operations, sometimes chained, sometimes poked with start mid-run
    rand_operands(ro, ra, rb, rd);
    issue(ro, ra, rb, rd);
    for (int i = 0; i < 40; i++) begin
      rand_operands(ro, ra, rb, rd);
      ch = (i != 39) && ($urandom_range(0, 1) == 1);
      wait_result($sformatf("rand%0d", i), ch, $urandom_range(0, 3) == 0, ro, ra, rb, rd);
      if (!ch && i != 39) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0 issue(ro, ra, rb, rd);
      end
    end
    check("queue drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
